// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared widths, resolution defaults and assembler state type
package cam_pkg;
    localparam int HRES_DEFAULT = 1280;
    localparam int VRES_DEFAULT = 720;
    localparam int HCOUNT_W     = 11;
    localparam int VCOUNT_W     = 10;
    localparam int PIXEL_W      = 16;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_HI    = 2'd1,
        WAIT_LO    = 2'd2
    } asm_state_t;
endpackage

// File: rtl/pclk_edge_detect.sv
// rtl/pclk_edge_detect.sv - rising-edge detector for the synchronized camera pixel clock
module pclk_edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pclk_in,
    output logic pclk_rise
);
    logic pclk_prev;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pclk_prev <= 1'b0;
        end else begin
            pclk_prev <= pclk_in;
        end
    end

    assign pclk_rise = pclk_in & ~pclk_prev;
endmodule

// File: rtl/camera_pixel_assembler.sv
// rtl/camera_pixel_assembler.sv - pairs camera bus bytes into tagged RGB565 pixels
module camera_pixel_assembler
    import cam_pkg::*;
#(
    parameter int HRES = HRES_DEFAULT,
    parameter int VRES = VRES_DEFAULT
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                camera_pclk_in,
    input  logic                camera_hs_in,
    input  logic                camera_vs_in,
    input  logic [7:0]          camera_data_in,
    output logic                data_valid_out,
    output logic [PIXEL_W-1:0]  pixel_data_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                frame_done_out
);
    localparam logic [HCOUNT_W-1:0] HLIM = HCOUNT_W'(HRES);
    localparam logic [VCOUNT_W-1:0] VLIM = VCOUNT_W'(VRES);
    localparam logic [HCOUNT_W-1:0] HMAX = '1;
    localparam logic [VCOUNT_W-1:0] VMAX = '1;

    logic                pclk_rise;
    asm_state_t          state;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic [7:0]          hi_byte;
    logic                hs_prev;
    logic                vs_prev;
    logic                frame_has_pixel;

    pclk_edge_detect u_edge (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pclk_in   (camera_pclk_in),
        .pclk_rise (pclk_rise)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= WAIT_FRAME;
            hcount          <= '0;
            vcount          <= '0;
            hi_byte         <= '0;
            hs_prev         <= 1'b0;
            vs_prev         <= 1'b0;
            frame_has_pixel <= 1'b0;
            data_valid_out  <= 1'b0;
            pixel_data_out  <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            frame_done_out  <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            if (pclk_rise) begin
                hs_prev <= camera_hs_in;
                vs_prev <= camera_vs_in;
                case (state)
                    WAIT_FRAME: begin
                        hcount <= '0;
                        vcount <= '0;
                        // vs_prev clears on reset, so a reset mid-frame needs a full VS pulse
                        if (vs_prev && !camera_vs_in) begin
                            state           <= WAIT_HI;
                            frame_has_pixel <= 1'b0;
                        end
                    end
                    default: begin
                        if (camera_vs_in) begin
                            state          <= WAIT_FRAME;
                            hcount         <= '0;
                            vcount         <= '0;
                            frame_done_out <= frame_has_pixel;
                        end else if (camera_hs_in) begin
                            if (state == WAIT_HI) begin
                                hi_byte <= camera_data_in;
                                state   <= WAIT_LO;
                            end else begin
                                if (hcount < HLIM && vcount < VLIM) begin
                                    data_valid_out  <= 1'b1;
                                    pixel_data_out  <= {hi_byte, camera_data_in};
                                    hcount_out      <= hcount;
                                    vcount_out      <= vcount;
                                    frame_has_pixel <= 1'b1;
                                end
                                if (hcount != HMAX) hcount <= hcount + 1'b1;
                                state <= WAIT_HI;
                            end
                        end else begin
                            // HS falling ends the line; an empty line leaves vcount alone
                            if (hs_prev) begin
                                if (hcount != '0 && vcount != VMAX) vcount <= vcount + 1'b1;
                                hcount <= '0;
                            end
                            state <= WAIT_HI;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_camera_pixel_assembler.sv
// tb/tb_camera_pixel_assembler.sv - directed self-checking bench for camera_pixel_assembler
module tb_camera_pixel_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pclk = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic [7:0]  data = 8'h00;

    logic        valid, fd, s_valid, s_fd;
    logic [15:0] pixel, s_pixel;
    logic [10:0] hcnt, s_hcnt;
    logic [9:0]  vcnt, s_vcnt;

    logic        c_valid, c_fd, cs_valid, cs_fd;
    logic [15:0] c_pix, cs_pix;
    logic [10:0] c_h, cs_h;
    logic [9:0]  c_v, cs_v;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0, n_s_valid = 0, n_fd = 0, n_s_fd = 0, n_b2b = 0;
    logic prev_valid = 1'b0, prev_s_valid = 1'b0;

    always #5 clk = ~clk;

    camera_pixel_assembler dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .camera_pclk_in (pclk),
        .camera_hs_in   (hs),
        .camera_vs_in   (vs),
        .camera_data_in (data),
        .data_valid_out (valid),
        .pixel_data_out (pixel),
        .hcount_out     (hcnt),
        .vcount_out     (vcnt),
        .frame_done_out (fd)
    );

    camera_pixel_assembler #(.HRES(4), .VRES(2)) dut_s (
        .clk_in         (clk),
        .rst_in         (rst),
        .camera_pclk_in (pclk),
        .camera_hs_in   (hs),
        .camera_vs_in   (vs),
        .camera_data_in (data),
        .data_valid_out (s_valid),
        .pixel_data_out (s_pixel),
        .hcount_out     (s_hcnt),
        .vcount_out     (s_vcnt),
        .frame_done_out (s_fd)
    );

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (s_valid) n_s_valid++;
        if (fd) n_fd++;
        if (s_fd) n_s_fd++;
        if ((valid && prev_valid) || (s_valid && prev_s_valid)) n_b2b++;
        prev_valid   = valid;
        prev_s_valid = s_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cam_byte(input logic h, input logic v, input logic [7:0] d);
        @(negedge clk);
        hs = h; vs = v; data = d; pclk = 1'b1;
        @(posedge clk);
        #1;
        c_valid = valid;    c_pix = pixel;    c_h = hcnt;    c_v = vcnt;    c_fd = fd;
        cs_valid = s_valid; cs_pix = s_pixel; cs_h = s_hcnt; cs_v = s_vcnt; cs_fd = s_fd;
        @(negedge clk);
        pclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo);
        cam_byte(1'b1, 1'b0, hi);
        cam_byte(1'b1, 1'b0, lo);
    endtask

    task automatic expect_pix(input string tag, input logic [15:0] p, input int h, input int v);
        check_eq({tag, "_valid"}, 32'(c_valid), 32'd1);
        check_eq({tag, "_pix"},   32'(c_pix),   32'(p));
        check_eq({tag, "_h"},     32'(c_h),     32'(h));
        check_eq({tag, "_v"},     32'(c_v),     32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_pix",   32'(pixel), 32'd0);
        check_eq("rst_fd",    32'(fd),    32'd0);
        rst = 1'b0;

        // frame start, first line 12 34 56 78
        cam_byte(1'b0, 1'b1, 8'h00);
        cam_byte(1'b0, 1'b0, 8'h00);
        cam_byte(1'b1, 1'b0, 8'h12);
        check_eq("hi_byte_no_valid", 32'(c_valid), 32'd0);
        cam_byte(1'b1, 1'b0, 8'h34);
        expect_pix("l0p0", 16'h1234, 0, 0);
        send_pix(8'h56, 8'h78);
        expect_pix("l0p1", 16'h5678, 1, 0);
        cam_byte(1'b0, 1'b0, 8'h00);
        check_eq("hold_pix", 32'(pixel), 32'h5678);

        send_pix(8'h11, 8'h22);
        expect_pix("l1p0", 16'h1122, 0, 1);
        send_pix(8'h33, 8'h44);
        expect_pix("l1p1", 16'h3344, 1, 1);
        cam_byte(1'b0, 1'b0, 8'h00);
        cam_byte(1'b0, 1'b0, 8'h00);
        cam_byte(1'b0, 1'b0, 8'h00);

        // odd byte line
        send_pix(8'hAA, 8'hBB);
        expect_pix("odd_p0", 16'hAABB, 0, 2);
        cam_byte(1'b1, 1'b0, 8'hCC);
        check_eq("odd_cc_valid", 32'(c_valid), 32'd0);
        cam_byte(1'b0, 1'b0, 8'h00);
        check_eq("odd_drop_valid", 32'(c_valid), 32'd0);

        // three pixels then VS in WAIT_LO
        send_pix(8'h01, 8'h02);
        expect_pix("ab_p0", 16'h0102, 0, 3);
        send_pix(8'h03, 8'h04);
        send_pix(8'h05, 8'h06);
        expect_pix("ab_p2", 16'h0506, 2, 3);
        cam_byte(1'b1, 1'b0, 8'h07);
        cam_byte(1'b1, 1'b1, 8'h08);
        check_eq("abort_valid", 32'(c_valid), 32'd0);
        check_eq("abort_fd",    32'(c_fd),    32'd1);
        check_eq("abort_s_fd",  32'(cs_fd),   32'd1);
        cam_byte(1'b0, 1'b0, 8'h00);
        send_pix(8'h9A, 8'hBC);
        expect_pix("nf_p0", 16'h9ABC, 0, 0);
        cam_byte(1'b0, 1'b1, 8'h00);
        check_eq("end_fd", 32'(c_fd), 32'd1);

        // empty frame
        cam_byte(1'b0, 1'b0, 8'h00);
        cam_byte(1'b0, 1'b1, 8'h00);
        check_eq("empty_fd", 32'(c_fd), 32'd0);

        // HRES=4 / VRES=2 limits on the small instance
        cam_byte(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            send_pix(8'(8'h20 + i), 8'(8'h30 + i));
            check_eq($sformatf("hlim_s_valid%0d", i), 32'(cs_valid), 32'(i < 4));
            check_eq($sformatf("hlim_h%0d", i), 32'(c_h), 32'(i));
        end
        check_eq("hlim_s_hold", 32'(cs_pix), 32'h2333);
        cam_byte(1'b0, 1'b0, 8'h00);
        send_pix(8'hA1, 8'hB1);
        check_eq("vlim_v1_s_valid", 32'(cs_valid), 32'd1);
        check_eq("vlim_v1_s_v",     32'(cs_v),     32'd1);
        cam_byte(1'b0, 1'b0, 8'h00);
        send_pix(8'hC1, 8'hD1);
        check_eq("vlim_v2_s_valid", 32'(cs_valid), 32'd0);
        check_eq("vlim_v2_s_pix",   32'(cs_pix),   32'hA1B1);
        expect_pix("vlim_big", 16'hC1D1, 0, 2);

        // asynchronous reset mid-pixel
        cam_byte(1'b1, 1'b0, 8'h55);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_pix",  32'(pixel), 32'd0);
        check_eq("arst_v",    32'(vcnt),  32'd0);
        check_eq("arst_s_pix", 32'(s_pixel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_pix(8'h12, 8'h34);
        check_eq("novs_valid",   32'(c_valid),  32'd0);
        check_eq("novs_s_valid", 32'(cs_valid), 32'd0);
        send_pix(8'h56, 8'h78);
        check_eq("novs_valid2",  32'(c_valid),  32'd0);

        repeat (3) @(negedge clk);
        check_eq("total_valid",   32'(n_valid),   32'd17);
        check_eq("total_s_valid", 32'(n_s_valid), 32'd10);
        check_eq("total_fd",      32'(n_fd),      32'd2);
        check_eq("total_s_fd",    32'(n_s_fd),    32'd2);
        check_eq("back_to_back",  32'(n_b2b),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
